// File: rtl/zeroheti_obi_banked_mem_if.sv
// OBI bus bundle for the banked memory: one request/response lane per port.
// The manager drives requests; the memory drives grant and response.
interface zeroheti_obi_banked_mem_if #(
    parameter int unsigned NumPorts = 2
);
    logic [NumPorts-1:0]       req;
    logic [NumPorts-1:0]       gnt;
    logic [NumPorts-1:0][31:0] addr;
    logic [NumPorts-1:0]       we;
    logic [NumPorts-1:0][3:0]  be;
    logic [NumPorts-1:0][31:0] wdata;
    logic [NumPorts-1:0]       rvalid;
    logic [NumPorts-1:0][31:0] rdata;
    logic [NumPorts-1:0]       err;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/zeroheti_obi_banked_mem.sv
// Multi-port word-interleaved SRAM with per-bank round-robin arbitration and
// one-cycle OBI responses. Define ZEROHETI_BANKMEM_ERR_EN to enable the range check.
module zeroheti_obi_banked_mem #(
    parameter int unsigned NumPorts = 2,
    parameter int unsigned NumBanks = 4,
    parameter int unsigned NumWords = 4096,
    parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
    input logic                      clk_i,
    input logic                      rst_ni,
    zeroheti_obi_banked_mem_if.slave obi
);
    localparam int unsigned RowsPerBank = NumWords / NumBanks;
    localparam int unsigned PortW       = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned BankW       = (NumBanks > 1) ? $clog2(NumBanks) : 1;
    localparam int unsigned RowW        = (RowsPerBank > 1) ? $clog2(RowsPerBank) : 1;

    logic [NumPorts-1:0][31:0]      word_off;
    logic [NumPorts-1:0][31:0]      word_idx;
    logic [NumPorts-1:0][BankW-1:0] port_bank;
    logic [NumPorts-1:0][RowW-1:0]  port_row;
    logic [NumPorts-1:0]            in_range;

    logic [NumBanks-1:0][PortW-1:0] rr_q, rr_d, win_port;
    logic [NumBanks-1:0]            win_valid;
    logic [NumBanks-1:0][RowW-1:0]  bank_row;
    logic [NumBanks-1:0]            bank_we;
    logic [NumBanks-1:0][3:0]       bank_be;
    logic [NumBanks-1:0][31:0]      bank_wdata, bank_rdata;

    logic [NumPorts-1:0]            gnt;
    logic [NumPorts-1:0]            rvalid_q, err_q, err_d;
    logic [NumPorts-1:0][31:0]      rdata_q, rdata_d;

    // Word offset relative to BaseAddr; low bits pick the bank, high bits the row.
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            word_off[p]  = (obi.addr[p] - BaseAddr) >> 2;
            word_idx[p]  = word_off[p] % NumWords;
            port_bank[p] = BankW'(word_idx[p] % NumBanks);
            port_row[p]  = RowW'(word_idx[p] / NumBanks);
`ifdef ZEROHETI_BANKMEM_ERR_EN
            in_range[p]  = (obi.addr[p] >= BaseAddr) && (word_off[p] < NumWords);
`else
            in_range[p]  = 1'b1;
`endif
        end
    end

    // Per-bank round-robin: first requesting port at or after rr_q, with wrap.
    always_comb begin
        logic [PortW-1:0] p;
        // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
        p         = '0;
        gnt       = '0;
        win_valid = '0;
        win_port  = '0;
        rr_d      = rr_q;
        for (int b = 0; b < NumBanks; b++) begin
            for (int k = 0; k < NumPorts; k++) begin
                p = PortW'((32'(rr_q[b]) + 32'(k)) % NumPorts);
                if (!win_valid[b] && obi.req[p] && in_range[p] && port_bank[p] == BankW'(b)) begin
                    win_valid[b] = 1'b1;
                    win_port[b]  = p;
                    gnt[p]       = 1'b1;
                end
            end
            if (win_valid[b]) begin
                rr_d[b] = PortW'((32'(win_port[b]) + 32'd1) % NumPorts);
            end
        end
        // Out-of-range requests bypass the banks and are granted at once.
        gnt = gnt | (obi.req & ~in_range);
    end

    always_comb begin
        for (int b = 0; b < NumBanks; b++) begin
            bank_row[b]   = port_row[win_port[b]];
            bank_we[b]    = win_valid[b] & obi.we[win_port[b]];
            bank_be[b]    = obi.be[win_port[b]];
            bank_wdata[b] = obi.wdata[win_port[b]];
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        logic [31:0] mem_q [RowsPerBank];

        // NOTE: the storage array has no reset; only control state is reset, so this maps onto plain SRAM.
        always_ff @(posedge clk_i) begin
            if (bank_we[b]) begin
                for (int i = 0; i < 4; i++) begin
                    if (bank_be[b][i]) begin
                        mem_q[bank_row[b]][8*i +: 8] <= bank_wdata[b][8*i +: 8];
                    end
                end
            end
        end

        // Sampled at the same edge as the write, so a read sees pre-write contents.
        assign bank_rdata[b] = mem_q[bank_row[b]];
    end

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            err_d[p]   = gnt[p] & ~in_range[p];
            rdata_d[p] = (gnt[p] && in_range[p] && !obi.we[p]) ? bank_rdata[port_bank[p]] : 32'h0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rr_q     <= rr_d;
            rvalid_q <= gnt;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign obi.gnt    = gnt;
    assign obi.rvalid = rvalid_q;
    assign obi.err    = err_q;
    assign obi.rdata  = rdata_q;
endmodule

// File: doc/zeroheti_obi_banked_mem.md
# zeroheti_obi_banked_mem

Multi-port, word-interleaved on-chip SRAM with OBI subordinate ports. It replaces the single-port instruction and data memories in the core subsystem. Each crossbar manager gets its own port, and accesses to different banks complete in parallel in the same cycle. Accesses that collide on one bank are arbitrated round-robin, independently per bank.

## Interface
Parameters:
- `NumPorts`, default 2: number of OBI subordinate ports; must be ≥1.
- `NumBanks`, default 4: number of interleaved banks; must be a power of two, ≥1.
- `NumWords`, default 4096: total 32-bit words; must be a multiple of `NumBanks`.
- `BaseAddr`, default 32'h0000_0000: byte address of word 0.

Ports (`[P]` means one entry per port, index 0..NumPorts-1):
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `req_i[P]` in 1: OBI request.
- `gnt_o[P]` out 1: OBI grant, combinational.
- `addr_i[P]` in 32: byte address.
- `we_i[P]` in 1: 1 = write.
- `be_i[P]` in 4: byte enables.
- `wdata_i[P]` in 32: write data.
- `rvalid_o[P]` out 1: response valid.
- `rdata_o[P]` out 32: read data.
- `err_o[P]` out 1: response error.

## Operation
- Address decode:
  - Word offset `w = (addr_i - BaseAddr) >> 2`; `addr_i[1:0]` is ignored.
  - Bank `= w mod NumBanks`; row `= w / NumBanks` (low bits / high bits of `w`).
- Arbitration, evaluated each cycle per bank:
  - Candidates are the ports with `req_i=1` whose address decodes to that bank.
  - Exactly one candidate is granted. The winner is the first candidate at or after the bank's round-robin pointer `rr[b]`, searching in increasing index with wrap-around.
  - After a grant, `rr[b]` becomes winner+1 modulo `NumPorts`. With no grant, `rr[b]` holds.
  - A non-granted port keeps its request stable (OBI rule) and retries next cycle.
- Access:
  - A granted write updates only the bytes where `be_i`=1.
  - A granted read captures the row's contents as they were before any write in that same cycle.
  - Only one port is granted per bank per cycle, so a same-cycle read/write on one word cannot occur.
- Response:
  - Every grant produces exactly one `rvalid_o` pulse on the same port in the next cycle.
  - Reads return the data; writes return `rdata_o=0`.
  - Each port has at most one outstanding transaction. Back-to-back grants to the same port are allowed because the response always follows in exactly one cycle.
- Read-after-write: a read granted in the cycle after a write to the same word returns the new data.
- Memory contents are not reset.

## Timing
- `gnt_o` is a combinational function of `req_i`, `addr_i` and the `rr` registers. There is no path from `we_i`/`wdata_i` to `gnt_o`.
- Read latency: `rvalid_o`/`rdata_o` are registered, one cycle after the `req_i`&&`gnt_o` handshake. Sustained throughput is one access per port per cycle when banks differ.
- Reset values: `rvalid_o=0`, `rdata_o=0`, `err_o=0`, all `rr[b]=0`.
- `gnt_o` is 0 for any port with `req_i=0`.
- Reset asserted mid-transaction: pending responses are dropped; no `rvalid_o` appears after reset release for a pre-reset grant.
- Simultaneous events:
  - All `NumPorts` ports may target distinct banks and all are granted in the same cycle.
  - Requests to the same bank are serialised, one per cycle, in round-robin order.

## Configuration
- `ZEROHETI_BANKMEM_ERR_EN` defined:
  - Range check applies to addresses below `BaseAddr` or at/above `BaseAddr + 4*NumWords`.
  - Such a request is granted immediately, without bank arbitration and without consuming any bank.
  - The response next cycle has `err_o=1` and `rdata_o=0`; a write is discarded.
- Macro not defined:
  - No range check; `err_o` is tied to 0.
  - `w` wraps modulo `NumWords`, so out-of-range addresses alias into the array.

## Test plan
- Reset: drive idle `req_i` and release `rst_ni` → `rvalid_o`, `err_o` and `rdata_o` stay 0 and no `gnt_o` is raised.
- Byte-masked write:
  - Port 0 writes 32'hDEAD_BEEF to 0x0 with `be=4'hF`, then 32'h0000_1200 with `be=4'b0010`.
  - Port 0 then reads 0x0 → `rdata_o=32'hDEAD_12EF`, `rvalid_o` exactly one cycle after the read grant.
- Parallel banks (`NumBanks=4`): port 0 reads 0x0 and port 1 reads 0x4 in the same cycle → both `gnt_o=1` in that cycle and both `rvalid_o=1` in the next.
- Bank conflict:
  - Ports 0 and 1 both hold requests to 0x10 for 4 cycles, reissuing each time they are granted.
  - Required grant sequence: 0,1,0,1; no starvation.
  - Each port receives exactly one `rvalid_o` per grant.
- Read-after-write: port 1 writes 32'h1234_5678 to 0x8, and port 0 reads 0x8 in the next cycle → returned data is 32'h1234_5678.
- Out-of-range access to `BaseAddr + 4*NumWords`:
  - With `ZEROHETI_BANKMEM_ERR_EN`: `err_o=1` and `rdata_o=0` one cycle after the grant, and word 0 is unchanged.
  - Without the macro: the write lands in word 0.
